btn_chord_cond: RTL and testbench
=================================

BTN_CHORD_COND -- requirements
Module: btn_chord_cond

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 1_000_000, consecutive stable cycles required to accept a key level change (10 ms at 100 MHz).
REQ-002 Parameter: CHORD_CYCLES, default 5_000_000, capture window length in cycles, opened by the first press of a chord (50 ms at 100 MHz).
REQ-003 Both parameters SHALL be >= 2; counter widths SHALL be $clog2(param) bits, with no wrap inside a window.
REQ-004 Port: clk, input, 1, system clock (100 MHz); single clock domain.
REQ-005 Port: rst, input, 1, reset, synchronous and active-high.
REQ-006 Port: key_n, input, 4, raw asynchronous board pushbuttons, active-low (0 = pressed).
REQ-007 Port: btn, output, 4, one-cycle chord code pulse that feeds the safe FSM button input; 0 when idle.
REQ-008 Port: key_held, output, 1, high while any debounced key is pressed.
REQ-009 Port: busy, output, 1, high in COLLECT, EMIT and WAIT_REL states.

Function
REQ-010 Each key_n bit SHALL pass through a 2-flop synchronizer, then be inverted to active-high raw[i].
REQ-011 Each key SHALL have an independent debouncer: deb[i] plus counter cnt[i].
REQ-012 Debounce rule: if raw[i] != deb[i], cnt[i] increments; if raw[i] == deb[i], cnt[i] clears to 0.
REQ-013 When raw[i] != deb[i] and cnt[i] == DEBOUNCE_CYCLES-1, deb[i] SHALL take raw[i] and cnt[i] SHALL clear to 0.
REQ-014 Any glitch shorter than DEBOUNCE_CYCLES SHALL leave deb[i] unchanged.
REQ-015 Latency from a stable key_n edge to the deb update SHALL be exactly 2 + DEBOUNCE_CYCLES clock edges.
REQ-016 The chord FSM SHALL have the states IDLE, COLLECT, EMIT and WAIT_REL, encoded one-hot.
REQ-017 IDLE: when |deb, go to COLLECT with acc <= deb and win <= 0; otherwise remain in IDLE.
REQ-018 COLLECT: each cycle acc <= acc | deb and win <= win + 1; when win == CHORD_CYCLES-1, go to EMIT.
REQ-019 A key released before the window ends SHALL stay in acc.
REQ-020 EMIT: btn SHALL equal acc for exactly this one cycle; then go to WAIT_REL.
REQ-021 The emitted code SHALL be nonzero; the window length SHALL be CHORD_CYCLES cycles from the IDLE->COLLECT edge.
REQ-022 WAIT_REL: stay until deb == 4'b0000, then go to IDLE; presses arriving in this state SHALL produce no event.
REQ-023 btn SHALL be 4'b0000 in every state except EMIT; at most one event per press-release group.
REQ-024 The btn output SHALL be driven directly from registers, with no combinational path from key_n.
REQ-025 key_held SHALL equal |deb, registered.
REQ-026 busy SHALL equal (state != IDLE), registered.
REQ-027 Simultaneous events: a new key press in the same cycle the window expires SHALL be ORed into acc before EMIT.
REQ-028 Simultaneous events: in EMIT, a key that is still held SHALL be ignored and the FSM SHALL proceed to WAIT_REL.
REQ-029 If all keys are released during COLLECT, the FSM SHALL still complete the window and emit acc.

Reset
REQ-030 On a clk edge with rst=1, all of the following SHALL clear: synchronizer flops to 0 (released), deb = 0, cnt = 0, acc = 0, win = 0.
REQ-031 On the same rst edge, state SHALL be IDLE, btn = 0, key_held = 0 and busy = 0.
REQ-032 Reset asserted mid-COLLECT or mid-EMIT SHALL abort with no pulse emitted.
REQ-033 After reset deasserts, keys already held SHALL re-debounce from zero and then start a new chord normally.
REQ-034 The block SHALL take no asynchronous action on rst.

Verification (DEBOUNCE_CYCLES=4, CHORD_CYCLES=8)
REQ-035 Scenario, single key: hold key_n=4'b1110 for 20 cycles -> deb[0] rises 6 edges after the input, then btn=4'b0001 for exactly 1 cycle, 8 cycles after entering COLLECT, then busy stays 1 until release is debounced.
REQ-036 Scenario, bounce: toggle key_n[2] with 3-cycle high/low periods for 30 cycles -> deb stays 0, btn stays 0, busy stays 0.
REQ-037 Scenario, staggered chord: press key 0, then keys 1 and 2 three cycles later, release key 0 at window cycle 5 -> single pulse btn=4'b0111.
REQ-038 Scenario, re-press during release: after an event, press key 3 while key 0 is still held -> no second pulse until all keys are released and pressed again.
REQ-039 Scenario, reset mid-window: assert rst at COLLECT window cycle 4 -> btn never pulses, all outputs are 0 on the next edge, and state is IDLE.
REQ-040 Scenario, back-to-back chords: two clean press/release sequences -> two separate one-cycle pulses, with btn=0 on every other cycle.

Source files
------------

// File: rtl/btn_chord_cond.sv
// Pushbutton conditioner: per-key synchronizer and debouncer, followed by a chord
// collector that emits one registered code pulse per press-release group.
module btn_chord_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CHORD_CYCLES    = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_n,
  output logic [3:0] btn,
  output logic       key_held,
  output logic       busy
);

  localparam int unsigned NK = 4;
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned CW = $clog2(CHORD_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] WIN_LAST = CW'(CHORD_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE     = 4'b0001,
    COLLECT  = 4'b0010,
    EMIT     = 4'b0100,
    WAIT_REL = 4'b1000
  } state_t;

  // Synchronizer flops hold the active-high level so that 0 means released.
  logic [NK-1:0] sync1;
  logic [NK-1:0] raw;
  logic [NK-1:0] deb;
  logic [DW-1:0] cnt [NK];

  state_t        state;
  state_t        state_n;
  logic [NK-1:0] acc;
  logic [NK-1:0] acc_n;
  logic [NK-1:0] btn_n;
  logic [CW-1:0] win;
  logic [CW-1:0] win_n;

  // Synchronize and debounce each key independently.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      raw   <= '0;
      deb   <= '0;
      for (int i = 0; i < NK; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= ~key_n;
      raw   <= sync1;
      for (int i = 0; i < NK; i++) begin
        if (raw[i] != deb[i]) begin
          if (cnt[i] == DEB_LAST) begin
            deb[i] <= raw[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + DW'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Chord state, accumulator, window counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      win      <= '0;
      btn      <= '0;
      key_held <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      acc      <= acc_n;
      win      <= win_n;
      btn      <= btn_n;
      key_held <= |deb;
      busy     <= (state_n != IDLE);
    end
  end

  // Next-state logic; btn_n is loaded only on the transition into EMIT.
  always_comb begin
    state_n = state;
    acc_n   = acc;
    win_n   = win;
    btn_n   = '0;
    unique case (state)
      IDLE: begin
        if (|deb) begin
          state_n = COLLECT;
          acc_n   = deb;
          win_n   = '0;
        end
      end
      COLLECT: begin
        acc_n = acc | deb;
        if (win == WIN_LAST) begin
          state_n = EMIT;
          win_n   = '0;
          btn_n   = acc | deb;
        end else begin
          win_n = win + CW'(1);
        end
      end
      EMIT: begin
        state_n = WAIT_REL;
      end
      WAIT_REL: begin
        if (deb == '0) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_btn_chord_cond.sv
// Self-checking bench for btn_chord_cond: directed scenarios plus random key
// activity, all compared against a cycle-level behavioural model.
module tb_btn_chord_cond;

  localparam int D = 4;
  localparam int C = 8;

  logic       clk;
  logic       rst;
  logic [3:0] key_n;
  logic [3:0] btn;
  logic       key_held;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  btn_chord_cond #(
    .DEBOUNCE_CYCLES(D),
    .CHORD_CYCLES   (C)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .key_n   (key_n),
    .btn     (btn),
    .key_held(key_held),
    .busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: a key level is accepted once the synchronized sample
  // has disagreed with it for D samples in a row; a chord window counts C edges.
  logic [3:0]   m_s1 = '0;
  logic [3:0]   m_s2 = '0;
  logic [3:0]   m_deb = '0;
  logic [D-1:0] m_hist [4] = '{default: '0};
  int           m_phase = 0;
  int           m_elapsed = 0;
  logic [3:0]   m_acc = '0;
  logic [3:0]   exp_btn = '0;
  logic         exp_held = 1'b0;
  logic         exp_busy = 1'b0;

  task automatic model_step();
    logic [3:0] raw_s;
    logic [3:0] old_deb;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_acc = '0;
      for (int i = 0; i < 4; i++) m_hist[i] = '0;
      m_phase = 0; m_elapsed = 0;
      exp_btn = '0; exp_held = 1'b0; exp_busy = 1'b0;
    end else begin
      raw_s   = m_s2;
      old_deb = m_deb;
      m_s2    = m_s1;
      m_s1    = ~key_n;
      for (int i = 0; i < 4; i++) begin
        m_hist[i] = {m_hist[i][D-2:0], raw_s[i]};
        if (m_hist[i] == {D{~old_deb[i]}}) m_deb[i] = raw_s[i];
      end
      exp_btn = '0;
      case (m_phase)
        0: if (old_deb != 4'b0000) begin
             m_phase = 1; m_acc = old_deb; m_elapsed = 0;
           end
        1: begin
             m_acc = m_acc | old_deb;
             m_elapsed++;
             if (m_elapsed == C) begin
               m_phase = 2; exp_btn = m_acc;
             end
           end
        2: m_phase = 3;
        default: if (old_deb == 4'b0000) m_phase = 0;
      endcase
      exp_busy = (m_phase != 0);
      exp_held = |old_deb;
    end
  endtask

  always @(posedge clk) model_step();

  logic [5:0] obs;
  logic [5:0] expv;
  assign obs  = {btn, key_held, busy};
  assign expv = {exp_btn, exp_held, exp_busy};

  task automatic test_reset();
    rst = 1'b1; key_n = 4'hF;
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs !== 6'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected %b", obs, 6'b0);
    end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL reset_idle: got %b expected %b", obs, expv);
      end
    end
  endtask

  task automatic test_single_key();
    int first_held = -1, first_busy = -1, last_busy = -1, pulses = 0, pulse_at = -1, gaps = 0;
    logic [3:0] pval = '0;
    for (int c = 1; c <= 40; c++) begin
      key_n = (c <= 20) ? 4'b1110 : 4'b1111;
      @(negedge clk);
      n_checks++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL single_model c=%0d: got %b expected %b", c, obs, expv);
      end
      if (key_held && first_held < 0) first_held = c;
      if (busy && first_busy < 0) first_busy = c;
      if (busy) last_busy = c;
      if (!busy && c >= 7 && c <= 26) gaps++;
      if (btn != 4'b0000) begin pulses++; pulse_at = c; pval = btn; end
    end
    n_checks++;
    if (first_held != 7) begin n_fail++; $display("FAIL single_held_latency: got %0d expected 7", first_held); end
    n_checks++;
    if (first_busy != 7) begin n_fail++; $display("FAIL single_busy_start: got %0d expected 7", first_busy); end
    n_checks++;
    if (pulses != 1 || pulse_at != 15 || pval !== 4'b0001) begin
      n_fail++; $display("FAIL single_pulse: got n=%0d at=%0d val=%b expected n=1 at=15 val=0001", pulses, pulse_at, pval);
    end
    n_checks++;
    if (last_busy != 26 || gaps != 0) begin
      n_fail++; $display("FAIL single_busy_span: got last=%0d gaps=%0d expected last=26 gaps=0", last_busy, gaps);
    end
  endtask

  task automatic test_bounce();
    int noisy = 0;
    for (int c = 1; c <= 40; c++) begin
      key_n = (c <= 30) ? {1'b1, logic'(((c - 1) / 3) % 2), 2'b11} : 4'b1111;
      @(negedge clk);
      n_checks++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL bounce_model c=%0d: got %b expected %b", c, obs, expv);
      end
      if (obs != 6'b0) noisy++;
    end
    n_checks++;
    if (noisy != 0) begin n_fail++; $display("FAIL bounce_quiet: got %0d active cycles expected 0", noisy); end
  endtask

  task automatic test_staggered();
    int pulses = 0;
    logic [3:0] pval = '0;
    for (int c = 1; c <= 40; c++) begin
      if (c < 4)       key_n = 4'b1110;
      else if (c < 12) key_n = 4'b1000;
      else if (c < 20) key_n = 4'b1001;
      else             key_n = 4'b1111;
      @(negedge clk);
      n_checks++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL stagger_model c=%0d: got %b expected %b", c, obs, expv);
      end
      if (btn != 4'b0000) begin pulses++; pval = btn; end
    end
    n_checks++;
    if (pulses != 1 || pval !== 4'b0111) begin
      n_fail++; $display("FAIL stagger_pulse: got n=%0d val=%b expected n=1 val=0111", pulses, pval);
    end
  endtask

  task automatic test_repress();
    int early = 0, pulses = 0;
    logic [3:0] p1 = '0, p2 = '0;
    for (int c = 1; c <= 100; c++) begin
      if (c < 20)      key_n = 4'b1110;
      else if (c < 35) key_n = 4'b0110;
      else if (c < 45) key_n = 4'b1110;
      else if (c < 60) key_n = 4'b1111;
      else if (c < 85) key_n = 4'b0111;
      else             key_n = 4'b1111;
      @(negedge clk);
      n_checks++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL repress_model c=%0d: got %b expected %b", c, obs, expv);
      end
      if (btn != 4'b0000) begin
        pulses++;
        if (c < 60) early++;
        if (pulses == 1) p1 = btn; else p2 = btn;
      end
    end
    n_checks++;
    if (early != 1 || pulses != 2 || p1 !== 4'b0001 || p2 !== 4'b1000) begin
      n_fail++; $display("FAIL repress_pulses: got early=%0d n=%0d p1=%b p2=%b expected 1 2 0001 1000", early, pulses, p1, p2);
    end
  endtask

  task automatic test_reset_mid_window();
    int pulses = 0, pulse_at = -1;
    for (int c = 1; c <= 60; c++) begin
      key_n = (c <= 40) ? 4'b1110 : 4'b1111;
      rst   = (c == 12);
      @(negedge clk);
      n_checks++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL rstwin_model c=%0d: got %b expected %b", c, obs, expv);
      end
      if (c == 12) begin
        n_checks++;
        if (obs !== 6'b0) begin n_fail++; $display("FAIL rstwin_clear: got %b expected %b", obs, 6'b0); end
      end
      if (btn != 4'b0000) begin pulses++; pulse_at = c; end
    end
    rst = 1'b0;
    n_checks++;
    if (pulses != 1 || pulse_at != 27) begin
      n_fail++; $display("FAIL rstwin_restart: got n=%0d at=%0d expected n=1 at=27", pulses, pulse_at);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    logic [3:0] p1 = '0, p2 = '0;
    for (int c = 1; c <= 80; c++) begin
      if (c < 25)      key_n = 4'b1100;
      else if (c < 40) key_n = 4'b1111;
      else if (c < 60) key_n = 4'b1011;
      else             key_n = 4'b1111;
      @(negedge clk);
      n_checks++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL b2b_model c=%0d: got %b expected %b", c, obs, expv);
      end
      if (btn != 4'b0000) begin
        pulses++;
        if (pulses == 1) p1 = btn; else p2 = btn;
      end
    end
    n_checks++;
    if (pulses != 2 || p1 !== 4'b0011 || p2 !== 4'b0100) begin
      n_fail++; $display("FAIL b2b_pulses: got n=%0d p1=%b p2=%b expected 2 0011 0100", pulses, p1, p2);
    end
  endtask

  task automatic test_random();
    int left = 0;
    for (int c = 0; c < 1500; c++) begin
      if (left == 0) begin
        key_n = 4'($urandom);
        left  = int'($urandom_range(1, 12));
        rst   = ($urandom_range(0, 49) == 0);
      end else begin
        rst = 1'b0;
      end
      left--;
      @(negedge clk);
      n_checks++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL random_model c=%0d: got %b expected %b", c, obs, expv);
      end
    end
    rst = 1'b0; key_n = 4'hF;
    repeat (30) begin
      @(negedge clk);
      n_checks++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL random_settle: got %b expected %b", obs, expv);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    key_n = 4'hF;
    test_reset();
    test_single_key();
    test_bounce();
    test_staggered();
    test_repress();
    test_reset_mid_window();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
